z80_bus_responder: RTL
======================

Name: z80_bus_responder

Overview:
- Synthesizable slave for the z80_top_direct_n pin bus. It replaces the behavioural test memory.
- Decodes Z80 memory, I/O and interrupt-acknowledge cycles, sampled on a system clock at least 2x the CPU CLK.
- Contains internal RAM, one I/O port register and an IM2 vector responder, and inserts programmable wait states via nWAIT.
- Uses split data-bus ports (D_out/D_oe/D_in); the top level builds the tristate.

Parameters:
- ADDR_W, 14: RAM depth is 2^ADDR_W bytes. A[15:ADDR_W] is ignored, so RAM aliases across the 64K space.
- MEM_WAIT, 1: system clocks nWAIT is held low on memory read/write cycles (0..15).
- IO_WAIT, 2: system clocks nWAIT is held low on I/O and interrupt-ack cycles (0..15).
- IO_PORT, 8'hFE: A[7:0] match for the port register.
- INT_VECTOR, 8'hFF: byte driven during interrupt acknowledge.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- A  in  16  CPU address bus
- D_in  in  8  CPU data bus, as seen by the responder
- D_out  out  8  read data
- D_oe  out  1  drive enable for D_out
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU control strobes, active-low
- nWAIT  out  1  to CPU, active-low
- io_in  in  8  value returned on reads of IO_PORT
- io_out  out  8  last byte written to IO_PORT
- io_wr  out  1  one-clock pulse on an IO_PORT write
- bus_err  out  1  sticky flag: nRD and nWR sampled low together

Behaviour:
- Reset values: D_out=0, D_oe=0, nWAIT=1, io_out=0, io_wr=0, bus_err=0, FSM=ARM. RAM contents are not reset.
- Input sampling: all CPU inputs are registered once (s_*). Decode uses only the s_* values. Edge k is the first edge at which s_* show a request.
- Request classes:
  - MRD: s_nMREQ=0, s_nRD=0
  - MWR: s_nMREQ=0, s_nWR=0
  - IORD: s_nIORQ=0, s_nRD=0, s_nM1=1
  - IOWR: s_nIORQ=0, s_nWR=0
  - INTA: s_nIORQ=0, s_nM1=0
  - Refresh (s_nRFSH=0 with s_nMREQ=0, s_nRD=1) is ignored.
- FSM states: ARM, IDLE, WAIT, ACTIVE, DONE.
- ARM: stay until s_nRD, s_nWR, s_nIORQ are all high, then go to IDLE. This blocks a spurious half-cycle after reset.
- IDLE, request at edge k:
  - latch address and class; load wait counter with MEM_WAIT or IO_WAIT.
  - count > 0: go to WAIT and set nWAIT=0 at edge k.
  - count = 0: go to ACTIVE; nWAIT stays 1.
- WAIT: decrement the counter each edge. At the edge where it reaches 0, set nWAIT=1 and go to ACTIVE. nWAIT is low for exactly N clocks.
- Read data:
  - RAM is read synchronously at edge k (address = A[ADDR_W-1:0]).
  - D_out valid and D_oe=1 from edge k+1 in every read class.
  - D_out source: MRD = RAM, IORD = io_in if A[7:0]==IO_PORT else 8'hFF, INTA = INT_VECTOR.
  - D_oe drops at the first edge where the read strobe (s_nRD, or s_nIORQ for INTA) is sampled high.
- Writes commit once per cycle, at the edge FSM enters ACTIVE, using s-registered D_in:
  - MWR: RAM[A[ADDR_W-1:0]] <= data.
  - IOWR with port match: io_out <= data, io_wr=1 for that edge only. Unmatched port writes are dropped.
- ACTIVE: go to DONE when all of s_nRD, s_nWR, s_nIORQ and s_nMREQ are sampled high (strobes ended).
- DONE: one clock, then IDLE. Back-to-back cycles need one idle edge, which is guaranteed by CPU timing at clock >= 2x CLK.
- Simultaneous s_nRD=0 and s_nWR=0 in IDLE: set bus_err, do not execute the cycle, go to ARM.
- Reset mid-cycle: the FSM returns to ARM next edge with nWAIT=1 and D_oe=0. A write not yet committed is discarded.
- Address wrap: 16'hFFFF with ADDR_W=14 accesses RAM[16'h3FFF]. 16'h4000 aliases to RAM[0].

Test Plan:
- Memory write then read: MWR A=16'h0123, D_in=8'hA5, then MRD A=16'h0123 (MEM_WAIT=1) -> nWAIT low exactly 1 clock each cycle; read gives D_oe=1 and D_out=8'hA5 from edge k+1; D_oe=0 after nRD rises.
- Aliasing: MWR A=16'h4000, D=8'h3C -> MRD A=16'h0000 returns 8'h3C; MRD A=16'hFFFF returns RAM[16'h3FFF].
- I/O port: IOWR A=16'h12FE, D=8'h77 -> io_out=8'h77 with io_wr high for one clock and nWAIT low 2 clocks; IORD A=16'h00FE with io_in=8'h5A -> D_out=8'h5A; IORD A=16'h00FD -> 8'hFF.
- Interrupt ack and refresh: nM1=0, nIORQ=0 -> D_out=8'hFF (INT_VECTOR), no RAM or port access; refresh cycle (nRFSH=0, nMREQ=0) -> D_oe stays 0, nWAIT stays 1.
- Reset mid-cycle: assert reset during the WAIT state of an MWR -> nWAIT=1 and D_oe=0 next edge, RAM unchanged; strobes still low after reset -> no response until they go high.
- Bus error: nRD and nWR driven low together -> bus_err=1 and stays set across later good cycles until reset.

Source files
------------

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 pin-bus slave with RAM, one I/O port, IM2 vector and wait states
//
// Purpose: responds to memory, I/O and interrupt-acknowledge cycles from a Z80
// core, sampling the pin bus on a system clock of at least 2x the CPU clock.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   A, D_in               CPU address bus and data bus as seen by the responder
//   D_out, D_oe           read data and its drive enable (tristate built above)
//   nM1 .. nRFSH          CPU control strobes, active-low
//   nWAIT                 wait request to the CPU, active-low
//   io_in, io_out, io_wr  port register read value, last written byte, write pulse
//   bus_err               sticky: nRD and nWR seen low together
module z80_bus_responder #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned IO_WAIT    = 2,
  parameter logic [7:0]  IO_PORT    = 8'hFE,
  parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  output logic        nWAIT,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic        io_wr,
  output logic        bus_err
);

  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_WAIT, ST_ACTIVE, ST_DONE} state_t;
  typedef enum logic [2:0] {CL_NONE, CL_MRD, CL_MWR, CL_IORD, CL_IOWR, CL_INTA} cls_t;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
  localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

  // High address bits take no part in decode, so RAM aliases across 64K.
  logic addr_hi_unused;
  assign addr_hi_unused = ^A[15:ADDR_W];

  // Input sampling: every decision below looks only at these copies.
  // Deliberately not reset, so strobes still low after reset keep ARM parked.
  logic [ADDR_W-1:0] s_a_q;
  logic [7:0]        s_d_q;
  logic s_nm1_q, s_nmreq_q, s_niorq_q, s_nrd_q, s_nwr_q, s_nrfsh_q;

  always_ff @(posedge clock) begin
    s_a_q     <= A[ADDR_W-1:0];
    s_d_q     <= D_in;
    s_nm1_q   <= nM1;
    s_nmreq_q <= nMREQ;
    s_niorq_q <= nIORQ;
    s_nrd_q   <= nRD;
    s_nwr_q   <= nWR;
    s_nrfsh_q <= nRFSH;
  end

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, req_cls, commit_cls;
  logic [3:0]        cnt_q, cnt_d, req_wait;
  logic [ADDR_W-1:0] a_q, a_d, commit_a;
  logic              nwait_q, nwait_d;
  logic [7:0]        d_out_q, d_out_d;
  logic              d_oe_q, d_oe_d;
  logic [7:0]        io_out_q, io_out_d;
  logic              io_wr_q, io_wr_d;
  logic              bus_err_q, bus_err_d;
  logic              enter_active, ram_we, rd_strobe_n;
  logic [7:0]        ram_rd_q;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  // Request classification; refresh (nRFSH low) never counts as a memory cycle.
  always_comb begin
    req_cls = CL_NONE;
    if (!s_niorq_q && !s_nm1_q)                     req_cls = CL_INTA;
    else if (!s_niorq_q && !s_nrd_q)                req_cls = CL_IORD;
    else if (!s_niorq_q && !s_nwr_q)                req_cls = CL_IOWR;
    else if (!s_nmreq_q && s_nrfsh_q && !s_nrd_q)   req_cls = CL_MRD;
    else if (!s_nmreq_q && s_nrfsh_q && !s_nwr_q)   req_cls = CL_MWR;
    req_wait = (req_cls == CL_MRD || req_cls == CL_MWR) ? MEM_WAIT_C : IO_WAIT_C;
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    nwait_d      = nwait_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    io_out_d     = io_out_q;
    io_wr_d      = 1'b0;
    bus_err_d    = bus_err_q;
    enter_active = 1'b0;
    commit_cls   = cls_q;
    commit_a     = a_q;
    rd_strobe_n  = 1'b1;

    case (state_q)
      ST_ARM: begin
        nwait_d = 1'b1;
        d_oe_d  = 1'b0;
        if (s_nrd_q && s_nwr_q && s_niorq_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        d_oe_d = 1'b0;
        if (!s_nrd_q && !s_nwr_q) begin
          bus_err_d = 1'b1;
          state_d   = ST_ARM;
        end else if (req_cls != CL_NONE) begin
          cls_d = req_cls;
          a_d   = s_a_q;
          if (req_wait != 4'd0) begin
            cnt_d   = req_wait;
            nwait_d = 1'b0;
            state_d = ST_WAIT;
          end else begin
            // Zero wait: commit straight from the sampled bus this edge.
            state_d      = ST_ACTIVE;
            enter_active = 1'b1;
            commit_cls   = req_cls;
            commit_a     = s_a_q;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          nwait_d      = 1'b1;
          state_d      = ST_ACTIVE;
          enter_active = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (s_nrd_q && s_nwr_q && s_niorq_q && s_nmreq_q) state_d = ST_DONE;
      end
      default: begin
        d_oe_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Read data is driven while the cycle's read strobe stays low.
    if ((state_q == ST_WAIT || state_q == ST_ACTIVE) &&
        (cls_q == CL_MRD || cls_q == CL_IORD || cls_q == CL_INTA)) begin
      rd_strobe_n = (cls_q == CL_INTA) ? s_niorq_q : s_nrd_q;
      if (rd_strobe_n) begin
        d_oe_d = 1'b0;
      end else begin
        d_oe_d = 1'b1;
        case (cls_q)
          CL_MRD:  d_out_d = ram_rd_q;
          CL_IORD: d_out_d = (a_q[7:0] == IO_PORT) ? io_in : 8'hFF;
          default: d_out_d = INT_VECTOR;
        endcase
      end
    end

    if (enter_active && commit_cls == CL_IOWR && commit_a[7:0] == IO_PORT) begin
      io_out_d = s_d_q;
      io_wr_d  = 1'b1;
    end
  end

  // Reset wins over a pending commit so an interrupted write is discarded.
  assign ram_we = enter_active && (commit_cls == CL_MWR) && !reset;

  always_ff @(posedge clock) begin
    if (ram_we) mem[commit_a] <= s_d_q;
    ram_rd_q <= mem[s_a_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_ARM;
      cls_q     <= CL_NONE;
      cnt_q     <= 4'd0;
      a_q       <= '0;
      nwait_q   <= 1'b1;
      d_out_q   <= 8'h00;
      d_oe_q    <= 1'b0;
      io_out_q  <= 8'h00;
      io_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      nwait_q   <= nwait_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
      io_out_q  <= io_out_d;
      io_wr_q   <= io_wr_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign D_out   = d_out_q;
  assign D_oe    = d_oe_q;
  assign nWAIT   = nwait_q;
  assign io_out  = io_out_q;
  assign io_wr   = io_wr_q;
  assign bus_err = bus_err_q;

endmodule
